// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single data-cache port between three requesters:
//   MH - miss-handler refill writes (highest priority, always wins)
//   RB - read-buffer lookups (normally ahead of WB)
//   WB - write-buffer drains (overtake RB once starved, or when alone)
// The port request is registered; a winner picked in cycle N appears on
// c_* in cycle N+1. Read responses come back one cycle after acceptance
// and are forwarded to the read buffer unless the read was flushed.
//
// Handshake semantics (all interfaces): a requester raises *_req with its
// fields and holds both stable until it sees a one-cycle *_ack. On the cache
// side a request is transferred in every cycle where c_valid & c_ready are
// both high; while c_valid & ~c_ready the c_* fields are held unchanged and
// the owner cannot be replaced.
module dcache_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // miss-handler refill writes
    input  logic        mh_req,
    input  logic [31:0] mh_addr,
    input  logic [31:0] mh_wdata,
    input  logic [3:0]  mh_strb,
    output logic        mh_ack,
    // write-buffer drains
    input  logic        wb_req,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_wdata,
    input  logic [3:0]  wb_strb,
    output logic        wb_ack,
    // read-buffer lookups and their responses
    input  logic        rb_req,
    input  logic [31:0] rb_addr,
    output logic        rb_ack,
    output logic        rb_rvalid,
    output logic [31:0] rb_rdata,
    // pipeline flush, kills read-buffer traffic
    input  logic        flush,
    // registered request to the dcache port
    output logic        c_valid,
    output logic [31:0] c_addr,
    output logic        c_wen,
    output logic [31:0] c_wdata,
    output logic [3:0]  c_strb,
    input  logic        c_ready,
    input  logic        c_rvalid,
    input  logic [31:0] c_rdata,
    output logic        busy,
    // observability of internal state
    output logic        dbg_state,
    output logic [1:0]  dbg_owner,
    output logic [2:0]  dbg_starve_cnt,
    output logic        dbg_kill
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_MH   = 2'd1,
        OWN_WB   = 2'd2,
        OWN_RB   = 2'd3
    } owner_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_e      state_q;
    owner_e      owner_q;
    logic [31:0] c_addr_q;
    logic        c_wen_q;
    logic [31:0] c_wdata_q;
    logic [3:0]  c_strb_q;
    logic [2:0]  starve_q;
    logic [2:0]  starve_d;
    logic        kill_q;
    logic        kill_d;

    logic        accept;
    logic        may_select;
    logic        mh_elig;
    logic        wb_elig;
    logic        rb_elig;
    owner_e      sel;
    logic [31:0] sel_addr;
    logic        sel_wen;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_strb;

    // Acceptance and winner selection; the accepted owner is masked so the
    // next request can be loaded in the same cycle without a bubble.
    always_comb begin
        accept     = (state_q == S_ISSUE) & c_ready;
        may_select = (state_q == S_IDLE) | accept;
        mh_elig    = mh_req & ~(accept & (owner_q == OWN_MH));
        wb_elig    = wb_req & ~(accept & (owner_q == OWN_WB));
        rb_elig    = rb_req & ~flush & ~(accept & (owner_q == OWN_RB));
        sel        = OWN_NONE;
        if (may_select) begin
            if (mh_elig) begin
                sel = OWN_MH;
            end else if (wb_elig && (!rb_elig || starve_q == LIMIT)) begin
                sel = OWN_WB;
            end else if (rb_elig) begin
                sel = OWN_RB;
            end
        end
    end

    // Field mux for the selected requester.
    always_comb begin
        sel_addr  = '0;
        sel_wen   = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        case (sel)
            OWN_MH: begin
                sel_addr  = mh_addr;
                sel_wen   = 1'b1;
                sel_wdata = mh_wdata;
                sel_strb  = mh_strb;
            end
            OWN_WB: begin
                sel_addr  = wb_addr;
                sel_wen   = 1'b1;
                sel_wdata = wb_wdata;
                sel_strb  = wb_strb;
            end
            OWN_RB: begin
                sel_addr  = rb_addr;
                sel_wen   = 1'b0;
            end
            default: begin
                sel_addr  = '0;
            end
        endcase
    end

    // WB starvation counter: counts cycles a WB request waits un-granted.
    always_comb begin
        starve_d = starve_q;
        if (!wb_req || sel == OWN_WB ||
            (state_q == S_ISSUE && owner_q == OWN_WB)) begin
            starve_d = 3'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 3'd1;
        end
    end

    // Kill flag: a flushed read still completes on the port, but its
    // response must not reach the read buffer.
    always_comb begin
        kill_d = kill_q;
        if (state_q == S_ISSUE && owner_q == OWN_RB && flush) begin
            kill_d = 1'b1;
        end else if (c_rvalid && kill_q) begin
            kill_d = 1'b0;
        end
    end

    // Main FSM: loads the winner into the port registers, holds them while
    // stalled, and reloads or goes idle on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            c_addr_q  <= '0;
            c_wen_q   <= 1'b0;
            c_wdata_q <= '0;
            c_strb_q  <= '0;
            starve_q  <= 3'd0;
            kill_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            kill_q   <= kill_d;
            case (state_q)
                S_IDLE, S_ISSUE: begin
                    if (may_select) begin
                        if (sel != OWN_NONE) begin
                            state_q   <= S_ISSUE;
                            owner_q   <= sel;
                            c_addr_q  <= sel_addr;
                            c_wen_q   <= sel_wen;
                            c_wdata_q <= sel_wdata;
                            c_strb_q  <= sel_strb;
                        end else begin
                            state_q <= S_IDLE;
                            owner_q <= OWN_NONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // Port outputs straight from registers.
    always_comb begin
        c_valid = (state_q == S_ISSUE);
        c_addr  = c_addr_q;
        c_wen   = c_wen_q;
        c_wdata = c_wdata_q;
        c_strb  = c_strb_q;
        busy    = (state_q == S_ISSUE);
    end

    // Acks pulse in the acceptance cycle; a flushed read gets none.
    always_comb begin
        mh_ack = accept & (owner_q == OWN_MH);
        wb_ack = accept & (owner_q == OWN_WB);
        rb_ack = accept & (owner_q == OWN_RB) & ~kill_q & ~flush;
    end

    // Read response forwarding, suppressed for killed reads and during flush.
    always_comb begin
        rb_rvalid = c_rvalid & ~kill_q & ~flush;
        rb_rdata  = c_rdata;
    end

    // Debug view of internal state.
    always_comb begin
        dbg_state      = state_q;
        dbg_owner      = owner_q;
        dbg_starve_cnt = starve_q;
        dbg_kill       = kill_q;
    end

endmodule
